// File: rtl/alu_seq_if.sv
// alu_seq_if: bus bundle between the microsequencer (master) and alu_seq (slave).
// Optional flag outputs exist only when ALU_SEQ_FLAGS_EN is defined.
interface alu_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [3:0]       ALUOP;
  logic [WIDTH-1:0] op1;
  logic [WIDTH-1:0] op2;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] data;
  logic             zero;
`ifdef ALU_SEQ_FLAGS_EN
  logic             carry;
  logic             overflow;
  logic             negative;

  modport master (
    output start, ALUOP, op1, op2,
    input  busy, done, data, zero, carry, overflow, negative
  );

  modport slave (
    input  start, ALUOP, op1, op2,
    output busy, done, data, zero, carry, overflow, negative
  );
`else
  modport master (
    output start, ALUOP, op1, op2,
    input  busy, done, data, zero
  );

  modport slave (
    input  start, ALUOP, op1, op2,
    output busy, done, data, zero
  );
`endif
endinterface

// File: rtl/alu_seq.sv
// alu_seq: registered multi-cycle ALU. Opcodes 0000-1001 complete in one
// cycle; shifts iterate one bit per clock; MUL is a WIDTH-step shift-add.
// Optional macro ALU_SEQ_FLAGS_EN adds registered carry/overflow/negative.
// WIDTH must be >= 4 (the A+4/A-4 constants need at least three bits plus sign).
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic      clk,
  input  logic      reset,
  alu_seq_if.slave  bus
);

  localparam int SHAMT_W = $clog2(WIDTH);
  // One extra bit so the counter can hold WIDTH for the multiply.
  localparam int CNT_W   = SHAMT_W + 1;

  localparam logic [3:0] OP_COPY_A = 4'b0000;
  localparam logic [3:0] OP_COPY_B = 4'b0001;
  localparam logic [3:0] OP_INC_1  = 4'b0010;
  localparam logic [3:0] OP_DEC_1  = 4'b0011;
  localparam logic [3:0] OP_INC_4  = 4'b0100;
  localparam logic [3:0] OP_DEC_4  = 4'b0101;
  localparam logic [3:0] OP_ADD    = 4'b0110;
  localparam logic [3:0] OP_SUB    = 4'b0111;
  localparam logic [3:0] OP_AND    = 4'b1000;
  localparam logic [3:0] OP_OR     = 4'b1001;
  localparam logic [3:0] OP_SLL    = 4'b1010;
  localparam logic [3:0] OP_SRL    = 4'b1011;
  localparam logic [3:0] OP_SRA    = 4'b1100;
  localparam logic [3:0] OP_SLT    = 4'b1101;
  localparam logic [3:0] OP_SLTU   = 4'b1110;
  localparam logic [3:0] OP_MUL    = 4'b1111;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_MUL, S_DONE} state_t;

  state_t             state_q;
  logic [3:0]         op_q;
  logic [WIDTH-1:0]   acc_q, mcand_q, mplier_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               busy_q, done_q, zero_q;
  logic [WIDTH-1:0]   data_q;

  logic [WIDTH-1:0]   addend_d, sum_d, result_d, shift_d, mul_d, commit_d;
  logic               cin_d, finish_d, is_shift;
  logic [SHAMT_W-1:0] shamt;
  logic [CNT_W-1:0]   cnt_dec;

  assign shamt    = bus.op2[SHAMT_W-1:0];
  assign is_shift = (bus.ALUOP == OP_SLL) || (bus.ALUOP == OP_SRL) || (bus.ALUOP == OP_SRA);
  assign cnt_dec  = cnt_q - CNT_W'(1);

  // Shared adder for INC/DEC/ADD/SUB; subtraction is A + ~B + 1.
  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    addend_d = '0;
    cin_d    = 1'b0;
    unique case (bus.ALUOP)
      OP_INC_1: addend_d = WIDTH'(1);
      OP_INC_4: addend_d = WIDTH'(4);
      OP_DEC_1: begin addend_d = ~WIDTH'(1); cin_d = 1'b1; end
      OP_DEC_4: begin addend_d = ~WIDTH'(4); cin_d = 1'b1; end
      OP_ADD:   addend_d = bus.op2;
      OP_SUB:   begin addend_d = ~bus.op2; cin_d = 1'b1; end
      default:  ;
    endcase
    sum_d = bus.op1 + addend_d + WIDTH'(cin_d);
  end

  // Single-cycle result; shift ops fall through to op1 for the shamt==0 case.
  always_comb begin
    result_d = bus.op1;
    unique case (bus.ALUOP)
      OP_COPY_A: result_d = bus.op1;
      OP_COPY_B: result_d = bus.op2;
      OP_INC_1, OP_DEC_1, OP_INC_4,
      OP_DEC_4, OP_ADD, OP_SUB:
                 result_d = sum_d;
      OP_AND:    result_d = bus.op1 & bus.op2;
      OP_OR:     result_d = bus.op1 | bus.op2;
      OP_SLT:    result_d = WIDTH'($signed(bus.op1) < $signed(bus.op2));
      OP_SLTU:   result_d = WIDTH'(bus.op1 < bus.op2);
      default:   result_d = bus.op1;
    endcase
  end

  // One iteration of the shifter and of the shift-add multiplier.
  always_comb begin
    unique case (op_q)
      OP_SLL:  shift_d = acc_q << 1;
      OP_SRL:  shift_d = acc_q >> 1;
      default: shift_d = {acc_q[WIDTH-1], acc_q[WIDTH-1:1]};
    endcase
    mul_d = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
  end

  // Decide whether this edge completes an operation, and with which value.
  always_comb begin
    finish_d = 1'b0;
    commit_d = mul_d;
    unique case (state_q)
      S_IDLE: begin
        finish_d = bus.start && (bus.ALUOP != OP_MUL) && !(is_shift && (shamt != '0));
        commit_d = result_d;
      end
      S_SHIFT: begin
        finish_d = (cnt_dec == '0);
        commit_d = shift_d;
      end
      S_MUL: begin
        finish_d = (cnt_dec == '0);
        commit_d = mul_d;
      end
      default: ;
    endcase
  end

`ifdef ALU_SEQ_FLAGS_EN
  logic carry_d, ovf_d, adder_op;
  logic carry_q, ovf_q;

  // Flags only come from the adder, and only on a single-cycle completion.
  always_comb begin
    adder_op = (state_q == S_IDLE) &&
               (bus.ALUOP inside {OP_INC_1, OP_DEC_1, OP_INC_4, OP_DEC_4, OP_ADD, OP_SUB});
    // Carry out of the MSB recovered from its inputs and sum bit.
    carry_d  = adder_op && ((bus.op1[WIDTH-1] & addend_d[WIDTH-1]) |
                            ((bus.op1[WIDTH-1] | addend_d[WIDTH-1]) & ~sum_d[WIDTH-1]));
    ovf_d    = adder_op && (bus.op1[WIDTH-1] == addend_d[WIDTH-1]) &&
                           (sum_d[WIDTH-1] != bus.op1[WIDTH-1]);
  end
`endif

  // Control FSM plus all registered outputs.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      // NOTE: datapath registers are reset too; there is no memory array whose contents could go unreset.
      state_q  <= S_IDLE;
      op_q     <= OP_COPY_A;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      data_q   <= '0;
      zero_q   <= 1'b1;
`ifdef ALU_SEQ_FLAGS_EN
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            op_q <= bus.ALUOP;
            if (bus.ALUOP == OP_MUL) begin
              acc_q    <= '0;
              mcand_q  <= bus.op1;
              mplier_q <= bus.op2;
              cnt_q    <= CNT_W'(WIDTH);
              busy_q   <= 1'b1;
              state_q  <= S_MUL;
            end else if (is_shift && (shamt != '0)) begin
              acc_q    <= bus.op1;
              cnt_q    <= {1'b0, shamt};
              busy_q   <= 1'b1;
              state_q  <= S_SHIFT;
            end
          end
        end
        S_SHIFT: begin
          acc_q <= shift_d;
          cnt_q <= cnt_dec;
        end
        S_MUL: begin
          acc_q    <= mul_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_dec;
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase

      // Completion overrides the state/busy updates above.
      if (finish_d) begin
        state_q <= S_DONE;
        busy_q  <= 1'b0;
        done_q  <= 1'b1;
        data_q  <= commit_d;
        zero_q  <= (commit_d == '0);
`ifdef ALU_SEQ_FLAGS_EN
        carry_q <= carry_d;
        ovf_q   <= ovf_d;
`endif
      end
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.data = data_q;
  assign bus.zero = zero_q;
`ifdef ALU_SEQ_FLAGS_EN
  assign bus.carry    = carry_q;
  assign bus.overflow = ovf_q;
  assign bus.negative = data_q[WIDTH-1];
`endif

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Registered, multi-cycle successor to the combinational datapath ALU, parametrised in WIDTH.
- Keeps opcodes 0000-1001 bit-for-bit.
- Adds iterative shifts, signed/unsigned compare and a shift-add multiply.
- Sits on the processor bus datapath. The microsequencer issues start, then stalls on busy until done, and the registered result drives the bus.

Parameters:
- WIDTH, 32, operand/result width; must be >= 4.
- SHAMT_W, $clog2(WIDTH), shift-amount width; derived localparam, not overridable.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request; sampled only while busy=0
- ALUOP  input  4  operation code, captured with start
- op1  input  WIDTH  operand A, captured with start
- op2  input  WIDTH  operand B, captured with start
- busy  output  1  high from the cycle after start is accepted until done
- done  output  1  one-cycle pulse; data valid in that cycle
- data  output  WIDTH  registered result; held until the next done
- zero  output  1  registered (data == 0)

Behaviour:
- Reset values: busy=0, done=0, data=0, zero=1; state IDLE.
- Reset is synchronous, active-high, on one clock (clk). Reset during SHIFT/MUL aborts the operation with no done pulse.
- States: IDLE, SHIFT, MUL, DONE.
- IDLE:
  - start=1 at edge N captures ALUOP, op1 and op2.
  - Single-cycle op: result computed and registered at edge N; goes to DONE.
  - SLL/SRL/SRA: acc=op1, cnt=op2[SHAMT_W-1:0]. Goes to DONE if cnt==0, else to SHIFT.
  - MUL: acc=0, mcand=op1, mplier=op2, cnt=WIDTH; goes to MUL.
- SHIFT: each edge shifts acc one bit and decrements cnt. Enters DONE on the edge where cnt reaches 0; data=acc.
- MUL: each edge adds mcand to acc if mplier[0]=1, then mcand<<=1, mplier>>=1, cnt-=1. Enters DONE when cnt reaches 0; data=acc (low WIDTH bits of the product).
- DONE: done=1, busy=0 for exactly one cycle, then IDLE. A start in this cycle is ignored.
- busy=1 exactly while the state is SHIFT or MUL.
- Latency (edge accepting start to the cycle done=1):
  - 1 cycle for single-cycle ops.
  - 1+shamt cycles for shifts.
  - WIDTH+1 cycles for MUL.
- start while busy=1 is ignored; operands are not re-captured.
- Opcodes (all arithmetic modulo 2^WIDTH, wrap-around, no saturation):
  - 0000 COPY_A
  - 0001 COPY_B
  - 0010 A+1
  - 0011 A-1
  - 0100 A+4
  - 0101 A-4
  - 0110 A+B
  - 0111 A-B
  - 1000 A&B
  - 1001 A|B
  - 1010 SLL
  - 1011 SRL
  - 1100 SRA (sign bit replicated)
  - 1101 SLT (signed A<B ? 1 : 0)
  - 1110 SLTU (unsigned)
  - 1111 MUL
- Shift amount uses only op2[SHAMT_W-1:0]; upper bits are ignored.
- zero is updated in the same edge as data; it is never combinational from the inputs.

Optional Feature:
- Macro: ALU_SEQ_FLAGS_EN.
- When defined, adds three outputs, all registered with data and reset to 0:
  - carry (output, 1): carry-out for ADD/INC; NOT borrow for SUB/DEC.
  - overflow (output, 1): signed overflow for ADD/SUB/INC/DEC.
  - negative (output, 1): data[WIDTH-1].
- carry and overflow are 0 for all other ops.
- When undefined, these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then ADD (0110) with op1=0xFFFF0000, op2=0x0000FFFF -> done one cycle after start, data=0xFFFFFFFF, zero=0, busy never high. Repeat with op1=0x4, op2=0xFFFFFFFC -> data=0, zero=1.
- Legacy sweep: every opcode 0000-1001 with the vectors 0x00000004-4 (DEC_A_4 -> 0) and 0xFFFFFFFF+1 (INC_A_1 -> 0) -> zero=1; one non-zero vector per opcode -> expected value, zero=0.
- SRA with op1=0x80000000, op2=0x00000024 (shamt=4) -> busy high 4 cycles, done at start+5, data=0xF8000000. SLL with shamt=0 -> done at start+1, data=op1.
- MUL with op1=0x00012345, op2=0x00000100 -> busy high 32 cycles, done at start+33, data=0x01234500. start pulsed mid-operation with different operands is ignored; result unchanged.
- Assert reset during MUL cycle 10 -> next cycle busy=0, data=0, zero=1, no done pulse; a new COPY_B with op2=0x5 then completes normally with data=0x5.
- Build with ALU_SEQ_FLAGS_EN: ADD 0x7FFFFFFF+1 -> overflow=1, negative=1, carry=0. SUB 0x0-0x1 -> carry=0, data=0xFFFFFFFF.
